// File: rtl/idu_pipe.sv
// idu_pipe: registered RV32I/RV64I decode stage between IFU and EXU.
// Define IDU_PIPE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module idu_pipe #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] imm_o,
    output logic [10:0]     op_info_o,
    output logic [5:0]      br_fun_o,
    output logic [6:0]      ld_fun_o,
    output logic [3:0]      st_fun_o,
    output logic [2:0]      fun3_o,
    output logic [6:0]      fun7_o,
    output logic            ebreak_o,
    output logic            illegal_o
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("idu_pipe: XLEN must be 32 or 64");
    end

    localparam bit IS64 = (XLEN == 64);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMMW  = 7'b0011011;
    localparam logic [6:0] OP_REGW  = 7'b0111011;
    localparam logic [6:0] OP_MISC  = 7'b0001111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [10:0]     op;
        logic [5:0]      br;
        logic [6:0]      ld;
        logic [3:0]      st;
        logic [2:0]      fun3;
        logic [6:0]      fun7;
        logic            eb;
        logic            ill;
    } entry_t;

    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [10:0] d_op;
    logic [5:0]  d_br;
    logic [6:0]  d_ld;
    logic [3:0]  d_st;
    logic        d_eb;
    logic        d_ill;
    logic        sh_chk;
    logic        r_chk;
    logic        sh_bad;
    logic        r_bad;
    logic [31:0] imm32;
    entry_t      d;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];

    // shamt is 6 bits wide on RV64, so bit 25 is reserved only on RV32
    always_comb begin
        sh_bad = 1'b0;
        if (IS64) begin
            if (f3 == 3'b001)
                sh_bad = in_instr[31:26] != 6'b000000;
            else if (f3 == 3'b101)
                sh_bad = in_instr[31:26] != 6'b000000
                      && in_instr[31:26] != 6'b010000;
        end else begin
            if (f3 == 3'b001)
                sh_bad = f7 != 7'b0000000;
            else if (f3 == 3'b101)
                sh_bad = f7 != 7'b0000000 && f7 != 7'b0100000;
        end
        r_bad = !(f7 == 7'b0000000
               || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
    end

    always_comb begin
        d_op   = '0;
        d_br   = '0;
        d_ld   = '0;
        d_st   = '0;
        d_eb   = 1'b0;
        d_ill  = 1'b0;
        sh_chk = 1'b0;
        r_chk  = 1'b0;
        unique case (1'b1)
            (opc == OP_LUI):   d_op[0] = 1'b1;
            (opc == OP_AUIPC): d_op[1] = 1'b1;
            (opc == OP_JAL):   d_op[2] = 1'b1;
            (opc == OP_JALR):  d_op[3] = 1'b1;
            (opc == OP_BR): begin
                d_op[4] = 1'b1;
                case (f3)
                    3'b000:  d_br[0] = 1'b1;
                    3'b001:  d_br[1] = 1'b1;
                    3'b100:  d_br[2] = 1'b1;
                    3'b101:  d_br[3] = 1'b1;
                    3'b110:  d_br[4] = 1'b1;
                    3'b111:  d_br[5] = 1'b1;
                    default: d_ill = 1'b1;
                endcase
            end
            (opc == OP_LD): begin
                d_op[5] = 1'b1;
                case (f3)
                    3'b000:  d_ld[0] = 1'b1;
                    3'b001:  d_ld[1] = 1'b1;
                    3'b010:  d_ld[2] = 1'b1;
                    3'b100:  d_ld[3] = 1'b1;
                    3'b101:  d_ld[4] = 1'b1;
                    3'b110:  begin d_ld[5] = IS64; d_ill = !IS64; end
                    3'b011:  begin d_ld[6] = IS64; d_ill = !IS64; end
                    default: d_ill = 1'b1;
                endcase
            end
            (opc == OP_ST): begin
                d_op[6] = 1'b1;
                case (f3)
                    3'b000:  d_st[0] = 1'b1;
                    3'b001:  d_st[1] = 1'b1;
                    3'b010:  d_st[2] = 1'b1;
                    3'b011:  begin d_st[3] = IS64; d_ill = !IS64; end
                    default: d_ill = 1'b1;
                endcase
            end
            (opc == OP_IMM): begin d_op[7] = 1'b1; sh_chk = 1'b1; end
            (opc == OP_REG): begin d_op[8] = 1'b1; r_chk = 1'b1; end
            (opc == OP_IMMW && IS64): begin
                d_op[9] = 1'b1;
                sh_chk  = 1'b1;
            end
            (opc == OP_REGW && IS64): begin
                d_op[10] = 1'b1;
                r_chk    = 1'b1;
            end
            (opc == OP_MISC): ;
            (opc == OP_SYS): begin
                d_eb  = in_instr == 32'h0010_0073;
                d_ill = in_instr != 32'h0010_0073;
            end
            default: d_ill = 1'b1;
        endcase
        if ((sh_chk && sh_bad) || (r_chk && r_bad))
            d_ill = 1'b1;
        if (d_ill) begin
            d_op = '0;
            d_br = '0;
            d_ld = '0;
            d_st = '0;
            d_eb = 1'b0;
        end
    end

    always_comb begin
        unique case (1'b1)
            (d_op[7] | d_op[9] | d_op[3] | d_op[5]):
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            d_op[6]:
                imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            d_op[4]:
                imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                         in_instr[11:8], 1'b0};
            (d_op[0] | d_op[1]):
                imm32 = {in_instr[31:12], 12'b0};
            d_op[2]:
                imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                         in_instr[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    always_comb begin
        d.pc   = in_pc;
        d.rs1  = in_instr[19:15];
        d.rs2  = in_instr[24:20];
        d.rd   = in_instr[11:7];
        d.imm  = XLEN'($signed(imm32));
        d.op   = d_op;
        d.br   = d_br;
        d.ld   = d_ld;
        d.st   = d_st;
        d.fun3 = f3;
        d.fun7 = f7;
        d.eb   = d_eb;
        d.ill  = d_ill;
    end

    entry_t main_q;
    logic   main_v;
    logic   push;
    logic   pop;

    assign push = in_valid && in_ready;
    assign pop  = main_v && out_ready;

`ifdef IDU_PIPE_SKID_EN
    entry_t skid_q;
    entry_t main_n;
    entry_t skid_n;
    logic   skid_v;
    logic   main_v_n;
    logic   skid_v_n;
    logic   rdy_q;

    assign in_ready = rdy_q;

    // skid refills main on pop so order is preserved
    always_comb begin
        main_n   = main_q;
        skid_n   = skid_q;
        main_v_n = main_v;
        skid_v_n = skid_v;
        if (!main_v) begin
            main_v_n = push;
            if (push)
                main_n = d;
        end else if (pop) begin
            if (skid_v) begin
                main_n   = skid_q;
                skid_v_n = 1'b0;
            end else if (push) begin
                main_n = d;
            end else begin
                main_v_n = 1'b0;
            end
        end else if (push) begin
            skid_n   = d;
            skid_v_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b1;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b1;
        end else begin
            main_q <= main_n;
            skid_q <= skid_n;
            main_v <= main_v_n;
            skid_v <= skid_v_n;
            rdy_q  <= !skid_v_n;
        end
    end
`else
    assign in_ready = !main_v || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q <= '0;
            main_v <= 1'b0;
        end else if (flush) begin
            main_v <= 1'b0;
        end else begin
            if (push)
                main_q <= d;
            main_v <= push || (main_v && !pop);
        end
    end
`endif

    assign out_valid = main_v;
    assign out_pc    = main_q.pc;
    assign rs1_o     = main_q.rs1;
    assign rs2_o     = main_q.rs2;
    assign rd_o      = main_q.rd;
    assign imm_o     = main_q.imm;
    assign op_info_o = main_q.op;
    assign br_fun_o  = main_q.br;
    assign ld_fun_o  = main_q.ld;
    assign st_fun_o  = main_q.st;
    assign fun3_o    = main_q.fun3;
    assign fun7_o    = main_q.fun7;
    assign ebreak_o  = main_q.eb;
    assign illegal_o = main_q.ill;

endmodule
